dtw_stim_streamer: RTL and testbench
====================================

// Module: dtw_stim_streamer
// PURPOSE
//  Synthesisable, parametrised source/sink traffic engine for dtw_core bring-up and on-chip self-test.
//  Streams LEN samples from a sample memory into dtw_core's first-word-fall-through src_fifo interface.
//  Optionally injects periodic empty bubbles on the source side and full back-pressure on the sink side.
//  Monitors sink writes: counts them and captures the first and last result words.
// PARAMETERS
//  DWIDTH      16  sample width, zero-extended onto the AXI_DWIDTH bus
//  AXI_DWIDTH  32  src/sink data bus width; must be >= DWIDTH
//  ADDR_W      15  sample-memory address width; max LEN = 2**ADDR_W
//  BUB_PERIOD   8  source bubble period in cycles, >= 2
//  BUB_LEN      1  bubble length in cycles, < BUB_PERIOD
//  BP_PERIOD    8  sink back-pressure period in cycles, >= 2
//  BP_LEN       2  back-pressure length in cycles, < BP_PERIOD
// PORTS
//  clk            in   1           clock
//  rst            in   1           synchronous, active-high reset
//  start          in   1           1-cycle pulse; ignored unless IDLE or DONE
//  len            in   ADDR_W+1    sample count, latched at start; 0 = immediate DONE
//  op_mode_in     in   1           0=query, 1=ref; latched at start
//  bub_en, bp_en  in   1 each      enable source bubbles / sink back-pressure
//  op_mode        out  1           latched mode, driven to dtw_core
//  running        out  1           high in PRIME/STREAM, drives dtw_core rs
//  done           out  1           high in DONE
//  mem_addr       out  ADDR_W      sample-memory read address
//  mem_rden       out  1           memory read enable; data valid the next cycle
//  mem_data       in   DWIDTH      sample-memory read data
//  src_fifo_empty out  1           FWFT empty toward dtw_core
//  src_fifo_rden  in   1           pop; accepted only when !src_fifo_empty
//  src_fifo_data  out  AXI_DWIDTH  {zeros, sample}; valid while !src_fifo_empty
//  sink_fifo_wren in   1           result write; accepted only when !sink_fifo_full
//  sink_fifo_full out  1           back-pressure toward dtw_core
//  sink_fifo_data in   AXI_DWIDTH  result word
//  sent_cnt       out  ADDR_W+1    samples popped
//  sink_cnt       out  32          sink writes accepted; saturates at 2**32-1
//  sink_first     out  AXI_DWIDTH  first accepted sink word since start
//  sink_last      out  AXI_DWIDTH  most recent accepted sink word
// BEHAVIOUR
//  Reset: state=IDLE; every output is 0 except src_fifo_empty=1. Counters, captures and phase counters clear.
//  FSM:
//   IDLE/DONE --start--> PRIME, or DONE directly if len==0.
//   PRIME: issue reads until the FWFT buffer holds data --> STREAM.
//   STREAM: sent_cnt==len_q --> DONE.
//   DONE: holds until the next start.
//  start: clears sent_cnt, sink_cnt and captures, and both phase counters.
//  Reads:
//   mem_rden=1 when rd_issued < len_q and (buffer occupancy + in-flight) < 2.
//   mem_addr starts at 0 and increments per issued read.
//   Latency: start at cycle t -> mem_rden at t+1 -> !src_fifo_empty at t+3 earliest.
//  FWFT buffer: 2 entries.
//   Pop when src_fifo_rden && !src_fifo_empty. Next entry is visible the following cycle.
//   Simultaneous push and pop is legal at any occupancy.
//   Overflow is impossible by the read-credit rule.
//  Source bubbles:
//   A free-running phase counter in 0..BUB_PERIOD-1.
//   When bub_en=1 and phase >= BUB_PERIOD-BUB_LEN, src_fifo_empty is forced to 1 and rden is ignored.
//  src_fifo_empty is also 1 when the buffer is empty, and in IDLE/DONE.
//  Sink back-pressure:
//   Independent phase counter; sink_fifo_full=1 when bp_en=1 and phase >= BP_PERIOD-BP_LEN.
//   A wren while full is dropped and not counted.
//  Sink monitor:
//   Active in every state except IDLE, so late results after DONE are still counted.
//   sink_first latches on the first accepted write only; sink_last updates on every accepted write.
//  Width: src_fifo_data = {(AXI_DWIDTH-DWIDTH)'b0, sample}.
//   len > 2**ADDR_W is clamped to 2**ADDR_W; addresses never wrap within a run.
//  rden while empty: no pop, no count change.
//  start while PRIME/STREAM: ignored.
//  rst mid-run: returns to IDLE next cycle; buffer flushed; in-flight read discarded.
// STRUCTURE
//  dtw_pkg: state encoding (IDLE, PRIME, STREAM, DONE) and the MODE_QUERY=0 / MODE_REF=1 constants.
//  Sub-module dtw_fwft_buf (parametrised WIDTH, DEPTH=2; push/pop/empty/count).
//  FSM, read-credit logic, pattern generators and sink monitor stay in the top level.
// TESTING
//  T1:
//   Stimulus: mem[i]=i+100, len=5, bub_en=bp_en=0, consumer holds rden=1.
//   Required: data 100..104 on 5 consecutive cycles from t+3; done at sent_cnt=5; empty=1 afterward.
//  T2:
//   Stimulus: as T1 with len=20, bub_en=1 (8/1).
//   Required: empty is 1 every 8th cycle; all 20 samples arrive in order with no duplicates.
//  T3:
//   Stimulus: consumer toggles rden 1/0; rden is also asserted during forced-empty cycles.
//   Required: sent_cnt counts only !empty pops; 20 samples arrive in order.
//  T4:
//   Stimulus: bp_en=1 (8/2); dtw_core-model issues wren every cycle with data=k.
//   Required: sink_cnt counts only writes when full=0; first=k at the first accepted write; last is correct.
//  T5:
//   Stimulus: len=0 start.
//   Required: DONE next cycle, mem_rden never asserts. Then len=40000 with ADDR_W=15.
//   Required: clamped to 32768; mem_addr ends at 32767.
//  T6:
//   Stimulus: rst pulsed mid-STREAM at sample 7, then restart with len=3.
//   Required: IDLE outputs as reset; restart delivers mem[0..2]; counters start from 0.

Source files
------------

// File: rtl/dtw_pkg.sv
// dtw_pkg: shared state encoding, mode constants and FWFT buffer sizing for the stim streamer
package dtw_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIME  = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } state_t;
    localparam logic MODE_QUERY = 1'b0;
    localparam logic MODE_REF   = 1'b1;
    localparam int FWFT_DEPTH = 2;
    localparam int FWFT_CW    = $clog2(FWFT_DEPTH + 1);
endpackage

// File: rtl/dtw_fwft_buf.sv
// dtw_fwft_buf: small first-word-fall-through buffer with concurrent push/pop at any occupancy
module dtw_fwft_buf #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_clr,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic             w_pop;
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];
    assign w_pop   = i_pop && !o_empty;
    // pointer and occupancy tracking; clear flushes without touching storage
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= (r_wr_ptr == PW'(DEPTH-1)) ? '0 : r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= (r_rd_ptr == PW'(DEPTH-1)) ? '0 : r_rd_ptr + 1'b1;
            r_count <= r_count + CW'(i_push) - CW'(w_pop);
        end
    end
    // storage is only ever read under a valid occupancy, so it needs no reset
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_data;
    end
endmodule

// File: rtl/dtw_stim_streamer.sv
// dtw_stim_streamer: streams sample memory into dtw_core's FWFT source port and monitors its sink writes
module dtw_stim_streamer
    import dtw_pkg::*;
#(
    parameter int DWIDTH     = 16,
    parameter int AXI_DWIDTH = 32,
    parameter int ADDR_W     = 15,
    parameter int BUB_PERIOD = 8,
    parameter int BUB_LEN    = 1,
    parameter int BP_PERIOD  = 8,
    parameter int BP_LEN     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_W:0]       len,
    input  logic                  op_mode_in,
    input  logic                  bub_en,
    input  logic                  bp_en,
    output logic                  op_mode,
    output logic                  running,
    output logic                  done,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_rden,
    input  logic [DWIDTH-1:0]     mem_data,
    output logic                  src_fifo_empty,
    input  logic                  src_fifo_rden,
    output logic [AXI_DWIDTH-1:0] src_fifo_data,
    input  logic                  sink_fifo_wren,
    output logic                  sink_fifo_full,
    input  logic [AXI_DWIDTH-1:0] sink_fifo_data,
    output logic [ADDR_W:0]       sent_cnt,
    output logic [31:0]           sink_cnt,
    output logic [AXI_DWIDTH-1:0] sink_first,
    output logic [AXI_DWIDTH-1:0] sink_last
);
    localparam int LW   = ADDR_W + 1;
    localparam int BUBW = $clog2(BUB_PERIOD);
    localparam int BPW  = $clog2(BP_PERIOD);
    localparam logic [LW-1:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
    state_t                r_state;
    state_t                w_next;
    logic [LW-1:0]         r_len_q;
    logic [LW-1:0]         r_rd_issued;
    logic [LW-1:0]         r_sent;
    logic                  r_inflight;
    logic                  r_op_mode;
    logic [BUBW-1:0]       r_bub_ph;
    logic [BPW-1:0]        r_bp_ph;
    logic [31:0]           r_sink_cnt;
    logic [AXI_DWIDTH-1:0] r_first;
    logic [AXI_DWIDTH-1:0] r_last;
    logic [LW-1:0]         w_len_clamped;
    logic                  w_start_ok;
    logic                  w_running;
    logic                  w_bubble;
    logic                  w_full;
    logic                  w_src_empty;
    logic                  w_pop;
    logic                  w_rden;
    logic                  w_sink_acc;
    logic                  w_buf_empty;
    logic [FWFT_CW-1:0]    w_buf_count;
    logic [DWIDTH-1:0]     w_buf_data;
    assign w_start_ok    = start && (r_state == IDLE || r_state == DONE);
    assign w_len_clamped = (len > MAX_LEN) ? MAX_LEN : len;
    assign w_running     = (r_state == PRIME) || (r_state == STREAM);
    assign w_bubble      = bub_en && (r_bub_ph >= BUBW'(BUB_PERIOD - BUB_LEN));
    assign w_full        = bp_en && (r_bp_ph >= BPW'(BP_PERIOD - BP_LEN));
    assign w_src_empty   = w_buf_empty || w_bubble || !w_running;
    assign w_pop         = src_fifo_rden && !w_src_empty;
    assign w_rden        = w_running && (r_rd_issued < r_len_q) &&
                           ((3'(w_buf_count) + 3'(r_inflight) - 3'(w_pop)) < 3'(FWFT_DEPTH));
    assign w_sink_acc    = sink_fifo_wren && !w_full && (r_state != IDLE);
    assign op_mode        = r_op_mode;
    assign running        = w_running;
    assign done           = (r_state == DONE);
    assign mem_addr       = (r_rd_issued == MAX_LEN) ? '1 : r_rd_issued[ADDR_W-1:0];
    assign mem_rden       = w_rden;
    assign src_fifo_empty = w_src_empty;
    assign src_fifo_data  = w_src_empty ? '0 : AXI_DWIDTH'(w_buf_data);
    assign sink_fifo_full = w_full;
    assign sent_cnt       = r_sent;
    assign sink_cnt       = r_sink_cnt;
    assign sink_first     = r_first;
    assign sink_last      = r_last;
    dtw_fwft_buf #(
        .WIDTH (DWIDTH),
        .DEPTH (FWFT_DEPTH)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_start_ok),
        .i_push  (r_inflight),
        .i_data  (mem_data),
        .i_pop   (w_pop),
        .o_data  (w_buf_data),
        .o_empty (w_buf_empty),
        .o_count (w_buf_count)
    );
    // run-control next state: a zero-length start skips straight to DONE
    always_comb begin
        w_next = r_state;
        if (w_start_ok) w_next = (w_len_clamped == '0) ? DONE : PRIME;
        else if (r_state == PRIME && !w_buf_empty) w_next = STREAM;
        else if (r_state == STREAM && r_sent == r_len_q) w_next = DONE;
    end
    // state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end
    // run parameters, read issue tracking and pop counting; a read in flight lands one cycle later
    always_ff @(posedge clk) begin
        if (rst) begin
            r_len_q     <= '0;
            r_op_mode   <= MODE_QUERY;
            r_rd_issued <= '0;
            r_sent      <= '0;
            r_inflight  <= 1'b0;
        end else begin
            r_inflight <= w_rden;
            if (w_start_ok) begin
                r_len_q     <= w_len_clamped;
                r_op_mode   <= op_mode_in;
                r_rd_issued <= '0;
                r_sent      <= '0;
            end else begin
                if (w_rden) r_rd_issued <= r_rd_issued + 1'b1;
                if (w_pop)  r_sent      <= r_sent + 1'b1;
            end
        end
    end
    // free-running bubble and back-pressure phases, realigned on every accepted start
    always_ff @(posedge clk) begin
        if (rst || w_start_ok) begin
            r_bub_ph <= '0;
            r_bp_ph  <= '0;
        end else begin
            r_bub_ph <= (r_bub_ph == BUBW'(BUB_PERIOD - 1)) ? '0 : r_bub_ph + 1'b1;
            r_bp_ph  <= (r_bp_ph == BPW'(BP_PERIOD - 1)) ? '0 : r_bp_ph + 1'b1;
        end
    end
    // sink monitor: saturating write count plus first/last accepted word capture
    always_ff @(posedge clk) begin
        if (rst || w_start_ok) begin
            r_sink_cnt <= '0;
            r_first    <= '0;
            r_last     <= '0;
        end else if (w_sink_acc) begin
            r_sink_cnt <= (r_sink_cnt == '1) ? r_sink_cnt : r_sink_cnt + 1'b1;
            if (r_sink_cnt == '0) r_first <= sink_fifo_data;
            r_last <= sink_fifo_data;
        end
    end
endmodule

// File: tb/tb_dtw_stim_streamer.sv
// tb_dtw_stim_streamer: randomized self-checking bench with a behavioural source/sink model
module tb_dtw_stim_streamer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] len = '0;
    logic        op_mode_in = 1'b0;
    logic        bub_en = 1'b0;
    logic        bp_en = 1'b0;
    logic        op_mode;
    logic        running;
    logic        done;
    logic [14:0] mem_addr;
    logic        mem_rden;
    logic [15:0] mem_data = '0;
    logic        src_fifo_empty;
    logic        src_fifo_rden = 1'b0;
    logic [31:0] src_fifo_data;
    logic        sink_fifo_wren = 1'b0;
    logic        sink_fifo_full;
    logic [31:0] sink_fifo_data = '0;
    logic [15:0] sent_cnt;
    logic [31:0] sink_cnt;
    logic [31:0] sink_first;
    logic [31:0] sink_last;
    int vec = 0;
    int errs = 0;
    int rd_total = 0;
    int last_rd_addr = -1;

    dtw_stim_streamer dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .len            (len),
        .op_mode_in     (op_mode_in),
        .bub_en         (bub_en),
        .bp_en          (bp_en),
        .op_mode        (op_mode),
        .running        (running),
        .done           (done),
        .mem_addr       (mem_addr),
        .mem_rden       (mem_rden),
        .mem_data       (mem_data),
        .src_fifo_empty (src_fifo_empty),
        .src_fifo_rden  (src_fifo_rden),
        .src_fifo_data  (src_fifo_data),
        .sink_fifo_wren (sink_fifo_wren),
        .sink_fifo_full (sink_fifo_full),
        .sink_fifo_data (sink_fifo_data),
        .sent_cnt       (sent_cnt),
        .sink_cnt       (sink_cnt),
        .sink_first     (sink_first),
        .sink_last      (sink_last)
    );

    always #5 clk = ~clk;

    // sample memory model: mem[i] = i + 100, one-cycle read latency
    always @(posedge clk) begin
        if (mem_rden) begin
            mem_data     <= 16'(int'(mem_addr) + 100);
            rd_total     <= rd_total + 1;
            last_rd_addr <= int'(mem_addr);
        end
    end

    task automatic check_idle_outputs(input string nm);
        vec++;
        if ({op_mode, running, done, mem_rden, src_fifo_empty, sink_fifo_full} !== 6'b000010) begin
            errs++;
            $display("FAIL %s flags: got mode/run/done/rden/empty/full=%b, need 000010", nm,
                     {op_mode, running, done, mem_rden, src_fifo_empty, sink_fifo_full});
        end
        vec++;
        if ({mem_addr, src_fifo_data, sent_cnt} !== '0) begin
            errs++;
            $display("FAIL %s src: got addr=%0d data=%0h sent=%0d, need all 0", nm, mem_addr, src_fifo_data, sent_cnt);
        end
        vec++;
        if ({sink_cnt, sink_first, sink_last} !== '0) begin
            errs++;
            $display("FAIL %s sink: got cnt=%0d first=%0h last=%0h, need all 0", nm, sink_cnt, sink_first, sink_last);
        end
    endtask

    // one run: the model expects samples 100,101,... in order, one per accepted pop
    task automatic run_stream(input string nm, input int l, input bit mode, input bit bub, input int rmode,
                              input bit mid, output int first_n, output bit gap);
        int exp_len, idx, last_n, budget;
        bit fin;
        exp_len = (l > 32768) ? 32768 : l;
        idx = 0; first_n = -1; last_n = -1; gap = 1'b0; fin = 1'b0;
        budget = 4 * exp_len + 40;
        @(negedge clk);
        len = 16'(l); op_mode_in = mode; bub_en = bub; start = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= budget && !fin; n++) begin
            @(negedge clk);
            start = mid && (n == 10);
            if (start) begin len = 16'd7; op_mode_in = !mode; end
            src_fifo_rden = (rmode == 0) ? 1'b1 : (rmode == 1) ? (n % 2 == 1 || n % 8 == 0) : 1'($urandom % 2);
            #1;
            if (n < 3) begin
                vec++;
                if (src_fifo_empty !== 1'b1) begin
                    errs++;
                    $display("FAIL %s early n=%0d: empty=%b, need 1", nm, n, src_fifo_empty);
                end
            end
            if (bub && n % 8 == 0) begin
                vec++;
                if (src_fifo_empty !== 1'b1) begin
                    errs++;
                    $display("FAIL %s bubble n=%0d: empty=%b, need 1", nm, n, src_fifo_empty);
                end
            end
            if (src_fifo_empty === 1'b0) begin
                if (first_n < 0) first_n = n;
                if (src_fifo_rden) begin
                    vec++;
                    if (src_fifo_data !== 32'(idx + 100)) begin
                        errs++;
                        $display("FAIL %s data #%0d: got %0d, need %0d", nm, idx, src_fifo_data, idx + 100);
                    end
                    if (last_n >= 0 && n != last_n + 1) gap = 1'b1;
                    last_n = n;
                    idx++;
                end
            end
            fin = (done === 1'b1);
        end
        start = 1'b0; src_fifo_rden = 1'b0;
        vec++;
        if (!fin) begin
            errs++;
            $display("FAIL %s done: timed out after %0d cycles, need done", nm, budget);
        end
        vec++;
        if (idx != exp_len || sent_cnt !== 16'(exp_len)) begin
            errs++;
            $display("FAIL %s count: got pops=%0d sent_cnt=%0d, need %0d", nm, idx, sent_cnt, exp_len);
        end
        vec++;
        if (src_fifo_empty !== 1'b1 || running !== 1'b0 || op_mode !== mode) begin
            errs++;
            $display("FAIL %s after: got empty=%b running=%b mode=%b, need 1 0 %b", nm, src_fifo_empty, running, op_mode, mode);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; bub_en = 1'b1; bp_en = 1'b1; src_fifo_rden = 1'b1;
        sink_fifo_wren = 1'b1; sink_fifo_data = 32'hdead_beef;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check_idle_outputs("reset");
        repeat (4) @(negedge clk);
        #1;
        check_idle_outputs("idle_hold");
        sink_fifo_wren = 1'b0; src_fifo_rden = 1'b0; bub_en = 1'b0; bp_en = 1'b0;
    endtask

    task automatic test_basic();
        int f, r0;
        bit g;
        r0 = rd_total;
        run_stream("t1", 5, 1'b1, 1'b0, 0, 1'b0, f, g);
        vec++;
        if (f != 3 || g) begin
            errs++;
            $display("FAIL t1 timing: got first=t+%0d gap=%b, need t+3 gap=0", f, g);
        end
        vec++;
        if (rd_total - r0 != 5 || mem_addr !== 15'd5) begin
            errs++;
            $display("FAIL t1 reads: got %0d reads addr=%0d, need 5 reads addr=5", rd_total - r0, mem_addr);
        end
    endtask

    task automatic test_bubbles();
        int f;
        bit g;
        run_stream("t2", 20, 1'b0, 1'b1, 0, 1'b0, f, g);
    endtask

    task automatic test_rden_toggle();
        int f;
        bit g;
        run_stream("t3", 20, 1'b1, 1'b1, 1, 1'b1, f, g);
    endtask

    task automatic test_random();
        int f;
        bit g;
        for (int k = 0; k < 6; k++)
            run_stream("rand", int'($urandom_range(60, 1)), 1'($urandom % 2), 1'($urandom % 2), 2, 1'b0, f, g);
    endtask

    task automatic test_backpressure();
        int cnt;
        logic [31:0] first, last, d;
        bit full_m;
        cnt = 0; first = '0; last = '0;
        @(negedge clk);
        len = '0; bp_en = 1'b1; bub_en = 1'b0; start = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            start = 1'b0;
            d = $urandom;
            sink_fifo_wren = 1'b1; sink_fifo_data = d;
            full_m = ((n - 1) % 8) >= 6;
            #1;
            vec++;
            if (sink_fifo_full !== full_m) begin
                errs++;
                $display("FAIL t4 full n=%0d: got %b, need %b", n, sink_fifo_full, full_m);
            end
            if (!full_m) begin
                cnt++;
                if (cnt == 1) first = d;
                last = d;
            end
        end
        @(negedge clk);
        sink_fifo_wren = 1'b0; bp_en = 1'b0;
        #1;
        vec++;
        if (sink_cnt !== 32'(cnt) || sink_first !== first || sink_last !== last) begin
            errs++;
            $display("FAIL t4 monitor: got cnt=%0d first=%0h last=%0h, need %0d %0h %0h",
                     sink_cnt, sink_first, sink_last, cnt, first, last);
        end
    endtask

    task automatic test_len_limits();
        int f, r0;
        bit g;
        r0 = rd_total;
        @(negedge clk);
        len = '0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        vec++;
        if (done !== 1'b1 || running !== 1'b0) begin
            errs++;
            $display("FAIL t5 zero: got done=%b running=%b, need 1 0", done, running);
        end
        repeat (5) @(negedge clk);
        vec++;
        if (rd_total != r0) begin
            errs++;
            $display("FAIL t5 zero reads: got %0d reads, need 0", rd_total - r0);
        end
        r0 = rd_total;
        run_stream("t5_clamp", 40000, 1'b0, 1'b0, 0, 1'b0, f, g);
        vec++;
        if (rd_total - r0 != 32768 || last_rd_addr != 32767 || mem_addr !== 15'd32767) begin
            errs++;
            $display("FAIL t5 clamp: got %0d reads last=%0d addr=%0d, need 32768 32767 32767",
                     rd_total - r0, last_rd_addr, mem_addr);
        end
    endtask

    task automatic test_reset_mid();
        int idx, f;
        bit g;
        idx = 0;
        @(negedge clk);
        len = 16'd20; op_mode_in = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 200 && idx < 7; n++) begin
            src_fifo_rden = 1'b1;
            #1;
            if (src_fifo_empty === 1'b0) begin
                vec++;
                if (src_fifo_data !== 32'(idx + 100)) begin
                    errs++;
                    $display("FAIL t6 pre data #%0d: got %0d, need %0d", idx, src_fifo_data, idx + 100);
                end
                idx++;
            end
            if (idx < 7) @(negedge clk);
        end
        rst = 1'b1; src_fifo_rden = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_idle_outputs("t6_rst");
        repeat (3) @(negedge clk);
        #1;
        check_idle_outputs("t6_flush");
        run_stream("t6_restart", 3, 1'b0, 1'b0, 0, 1'b0, f, g);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bubbles();
        test_rden_toggle();
        test_backpressure();
        test_random();
        test_len_limits();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
